cb_dispatch: RTL

- Initiator side of the start/ready/valid handshake exposed by the datapath control block.
- Buffers incoming operands in a small FIFO and issues one start per operand to the datapath. It holds the operand stable while the datapath computes, then captures the result when the datapath signals valid.
- Presents each result to a downstream consumer through a valid/ready handshake.
- Recovers a hung datapath with a timeout that pulses the datapath reset.

---
 rtl/cb_dispatch_pkg.sv | 29 ++
 rtl/cb_op_fifo.sv | 64 ++++++
 rtl/cb_dispatch.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cb_dispatch_pkg.sv
// Shared definitions for the datapath dispatch block: FSM state encoding,
// parameter defaults and a constant-width helper.
package cb_dispatch_pkg;

  // Default sizing for the dispatcher and its operand FIFO.
  localparam int CB_WIDTH   = 8;
  localparam int CB_RWIDTH  = 16;
  localparam int CB_DEPTH   = 4;
  localparam int CB_TIMEOUT = 16;

  // Dispatcher FSM states; the numeric values are visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ABORT = 2'd3
  } cb_state_e;

  // Ceiling log2, used for counter and pointer widths at elaboration time.
  function automatic int cb_clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/cb_op_fifo.sv
// Synchronous operand FIFO. DEPTH is a power of two so the read and write
// pointers wrap naturally. A push while full or a pop while empty is ignored.
module cb_op_fifo
  import cb_dispatch_pkg::*;
#(
  parameter int WIDTH = CB_WIDTH,
  parameter int DEPTH = CB_DEPTH,
  localparam int AW = (DEPTH > 1) ? cb_clog2(DEPTH) : 1,
  localparam int CW = cb_clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The head entry is always visible so the consumer can register it on the pop edge.
  assign dout = mem[rd_ptr];

  // Storage array; contents need no reset because count guards every read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cb_dispatch.sv
// Initiator for the datapath start/ready/valid protocol. Operands are queued
// in a small FIFO, issued one at a time with a single-cycle start pulse, and
// the datapath result is held for a downstream valid/ready consumer. A
// datapath that never answers is recovered by a timeout that pulses its reset
// and reports an error result.
//
// Handshakes:
//   in_valid/in_ready   : an operand transfers on a rising edge where both are
//                         high; in_ready depends only on FIFO occupancy.
//   out_valid/out_ready : out_valid, out_result and out_error hold steady until
//                         a rising edge where both valid and ready are high;
//                         out_valid drops on that edge.
//   dp_start/dp_valid   : a start is only sent when the datapath reports ready
//                         and is not simultaneously presenting a result, since
//                         its final state raises ready together with valid.
//                         dp_valid is only honoured while waiting for a result.
module cb_dispatch
  import cb_dispatch_pkg::*;
#(
  parameter int WIDTH   = CB_WIDTH,
  parameter int RWIDTH  = CB_RWIDTH,
  parameter int DEPTH   = CB_DEPTH,
  parameter int TIMEOUT = CB_TIMEOUT,
  localparam int CW = cb_clog2(DEPTH + 1),
  localparam int TW = (TIMEOUT > 1) ? cb_clog2(TIMEOUT) : 1
) (
  input  logic              clock,
  input  logic              reset,
  // operand intake
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_x,
  // datapath control
  output logic              dp_start,
  output logic              dp_reset,
  output logic [WIDTH-1:0]  dp_x,
  input  logic              dp_ready,
  input  logic              dp_valid,
  input  logic [RWIDTH-1:0] dp_result,
  // result delivery
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RWIDTH-1:0] out_result,
  output logic              out_error,
  // status
  output logic              busy,
  output logic [CW-1:0]     count,
  output logic [1:0]        state
);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  cb_state_e        state_q;
  logic [TW-1:0]    timer_q;
  logic             abort_q;

  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             issue_ok;

  // Launch condition for a new operand: something queued, datapath idle and
  // not showing a result, and no undelivered result that would be overwritten.
  assign issue_ok = (state_q == ST_IDLE) && !fifo_empty && dp_ready &&
                    !dp_valid && !out_valid;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = issue_ok;

  // The datapath is reset by the block reset and by the one-cycle abort pulse.
  assign dp_reset = reset || abort_q;

  assign busy  = (state_q != ST_IDLE) || (count != '0) || out_valid;
  assign state = state_q;

  cb_op_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_x),
    .dout  (fifo_dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Dispatch FSM with its timer, registered datapath controls and result register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      abort_q    <= 1'b0;
      dp_start   <= 1'b0;
      dp_x       <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_error  <= 1'b0;
    end else begin
      // Start and abort are single-cycle pulses that follow the state.
      dp_start <= 1'b0;
      abort_q  <= 1'b0;

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (issue_ok) begin
            state_q  <= ST_ISSUE;
            dp_x     <= fifo_dout;
            dp_start <= 1'b1;
          end
        end

        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (dp_valid) begin
            out_result <= dp_result;
            out_error  <= 1'b0;
            out_valid  <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (timer_q == TIMER_LAST) begin
            abort_q <= 1'b1;
            state_q <= ST_ABORT;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        ST_ABORT: begin
          out_result <= '0;
          out_error  <= 1'b1;
          out_valid  <= 1'b1;
          state_q    <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
